c7bbiu_icrd: RTL and testbench

Instruction-fetch read responder inside the BIU. It accepts cache-line and single-beat read requests from the instruction cache unit, issues one AXI4 read burst per request, and returns the read data to the instruction cache as registered 64-bit beats with valid, last and fault flags. It sits between the instruction cache's BIU port and the system AXI read channels (AR/R). Write channels are owned by another block.

---
 rtl/c7bbiu_icrd.sv | 126 ++++++++++++
 tb/tb_c7bbiu_icrd.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/c7bbiu_icrd.sv
// Instruction-fetch read responder: turns ICU line/single fetch requests into one
// AXI4 INCR read burst each and returns registered 64-bit beats with last/fault flags.
module c7bbiu_icrd #(
  parameter int          LINE_BEATS = 4,
  parameter logic [3:0]  ARID       = 4'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        icu_biu_req,
  input  logic [31:3] icu_biu_addr,
  input  logic        icu_biu_single,
  output logic        biu_icu_ack,
  output logic        biu_icu_data_valid,
  output logic        biu_icu_data_last,
  output logic [63:0] biu_icu_data,
  output logic        biu_icu_fault,
  output logic        arvalid,
  input  logic        arready,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  input  logic        rvalid,
  output logic        rready,
  input  logic [3:0]  rid,
  input  logic [63:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast
);
  localparam int         BEAT_W   = $clog2(LINE_BEATS);
  localparam int         CNT_W    = BEAT_W + 1;
  localparam logic [7:0] LINE_LEN = 8'(LINE_BEATS - 1);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, DRAIN} state_t;

  state_t           state;
  logic [CNT_W-1:0] beat_cnt;
  logic             vld_p1;
  logic             last_p1;
  logic             fault_p1;
  logic [63:0]      data_p1;
  logic             r_hs;
  logic             exp_last;
  logic             early_last;
  logic             miss_last;
  logic             unused_rid;

  assign unused_rid = ^rid;

  // The final beat is presented while already in IDLE; hold off the next ack one cycle.
  assign biu_icu_ack = (state == IDLE) & icu_biu_req & ~vld_p1;
  assign arvalid     = (state == ADDR);
  assign rready      = (state == DATA) | (state == DRAIN);
  assign arid        = ARID;

  assign r_hs       = rvalid & (state == DATA);
  assign exp_last   = (beat_cnt == arlen[CNT_W-1:0]);
  assign early_last = rlast & ~exp_last;
  assign miss_last  = exp_last & ~rlast;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      beat_cnt <= '0;
      araddr   <= '0;
      arlen    <= '0;
      arsize   <= '0;
      arburst  <= '0;
      vld_p1   <= 1'b0;
      last_p1  <= 1'b0;
      fault_p1 <= 1'b0;
      data_p1  <= '0;
    end else begin
      // R channel -> registered ICU return beat (p1)
      vld_p1   <= r_hs;
      last_p1  <= 1'b0;
      fault_p1 <= 1'b0;
      if (r_hs) begin
        data_p1  <= rdata;
        last_p1  <= exp_last | rlast;
        fault_p1 <= rresp[1] | early_last | miss_last;
      end

      case (state)
        IDLE: begin
          if (biu_icu_ack) begin
            if (icu_biu_single) begin
              araddr <= {icu_biu_addr, 3'b000};
              arlen  <= 8'd0;
            end else begin
              araddr <= {icu_biu_addr[31:3+BEAT_W], {(3+BEAT_W){1'b0}}};
              arlen  <= LINE_LEN;
            end
            arsize  <= 3'b011;
            arburst <= 2'b01;
            state   <= ADDR;
          end
        end
        ADDR: begin
          if (arready) begin
            beat_cnt <= '0;
            state    <= DATA;
          end
        end
        DATA: begin
          if (rvalid) begin
            beat_cnt <= beat_cnt + 1'b1;
            if (rlast)         state <= IDLE;
            else if (exp_last) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (rvalid & rlast) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign biu_icu_data_valid = vld_p1;
  assign biu_icu_data_last  = last_p1;
  assign biu_icu_fault      = fault_p1;
  assign biu_icu_data       = data_p1;

endmodule

// File: tb/tb_c7bbiu_icrd.sv
// Scoreboard bench for c7bbiu_icrd: a request driver pushes expected AR and return beats,
// an AXI read-slave model answers bursts, and a monitor pops and compares DUT output.
module tb_c7bbiu_icrd;
  localparam int LB = 4;

  logic        clk;
  logic        reset;
  logic        icu_biu_req;
  logic [31:3] icu_biu_addr;
  logic        icu_biu_single;
  logic        biu_icu_ack;
  logic        biu_icu_data_valid;
  logic        biu_icu_data_last;
  logic [63:0] biu_icu_data;
  logic        biu_icu_fault;
  logic        arvalid;
  logic        arready;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        rvalid;
  logic        rready;
  logic [3:0]  rid;
  logic [63:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;

  c7bbiu_icrd #(.LINE_BEATS(LB), .ARID(4'h0)) dut (
    .clk(clk), .reset(reset),
    .icu_biu_req(icu_biu_req), .icu_biu_addr(icu_biu_addr), .icu_biu_single(icu_biu_single),
    .biu_icu_ack(biu_icu_ack), .biu_icu_data_valid(biu_icu_data_valid),
    .biu_icu_data_last(biu_icu_data_last), .biu_icu_data(biu_icu_data),
    .biu_icu_fault(biu_icu_fault),
    .arvalid(arvalid), .arready(arready), .arid(arid), .araddr(araddr), .arlen(arlen),
    .arsize(arsize), .arburst(arburst),
    .rvalid(rvalid), .rready(rready), .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast)
  );

  typedef struct { logic [63:0] data; logic last; logic fault; } beat_t;
  typedef struct { logic [31:0] addr; logic [7:0] len; } ar_t;
  typedef struct { int total; int err; int gap; int arw; logic [63:0] base; } scfg_t;

  beat_t expq[$];
  ar_t   arq[$];
  scfg_t cfgq[$];
  int    dv_cycq[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ack_cnt = 0;
  int beats_rx = 0;
  int last_dv_cyc = 0;
  int txn_ack_cyc = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor: sampled on the falling edge, away from the active edge
  initial begin
    ar_t         ea;
    beat_t       eb;
    logic        pv, pr;
    logic [31:0] pa;
    logic [7:0]  pl;
    pv = 1'b0; pr = 1'b0; pa = '0; pl = '0;
    forever begin
      @(negedge clk);
      if (biu_icu_ack === 1'b1) ack_cnt++;
      if (pv && !pr && arvalid) begin
        chk("ar_stable_addr", araddr, pa);
        chk("ar_stable_len", arlen, pl);
      end
      pv = arvalid; pr = arready; pa = araddr; pl = arlen;
      if (arvalid && arready) begin
        chk("ar_expected", arq.size() != 0, 1);
        if (arq.size() != 0) begin
          ea = arq.pop_front();
          chk("araddr", araddr, ea.addr);
          chk("arlen", arlen, ea.len);
          chk("arsize", arsize, 3'b011);
          chk("arburst", arburst, 2'b01);
          chk("arid", arid, 4'h0);
        end
      end
      if (biu_icu_data_valid) begin
        chk("no_ack_during_dv", biu_icu_ack, 0);
        beats_rx++;
        dv_cycq.push_back(cyc);
        if (biu_icu_data_last) last_dv_cyc = cyc;
        chk("beat_expected", expq.size() != 0, 1);
        if (expq.size() != 0) begin
          eb = expq.pop_front();
          chk("beat_data", biu_icu_data, eb.data);
          chk("beat_last", biu_icu_data_last, eb.last);
          chk("beat_fault", biu_icu_fault, eb.fault);
        end
      end else begin
        chk("idle_last", biu_icu_data_last, 0);
        chk("idle_fault", biu_icu_fault, 0);
      end
    end
  end

  // AXI read-slave model: per-burst behaviour comes from cfgq in request order
  initial begin
    int          phase, idx, armed, arw_left, total, err, gap;
    logic [63:0] base;
    logic        ar_hs, r_hs;
    scfg_t       c;
    arready = 0; rvalid = 0; rlast = 0; rdata = '0; rresp = '0; rid = '0;
    phase = 0; idx = 0; armed = 0; arw_left = 0; total = 0; err = -1; gap = 0; base = '0;
    forever begin
      @(negedge clk);
      ar_hs = arvalid && arready;
      r_hs  = rvalid && rready;
      @(posedge clk);
      #1;
      if (reset) begin
        phase = 0; armed = 0; arready = 0; rvalid = 0; rlast = 0;
      end else begin
        if (phase == 0) begin
          if (ar_hs && cfgq.size() != 0) begin
            c = cfgq.pop_front();
            total = c.total; err = c.err; gap = c.gap; base = c.base;
            phase = 1; idx = 0; armed = 0; arready = 0; rvalid = 0;
          end else begin
            if (!armed && cfgq.size() != 0) begin
              arw_left = cfgq[0].arw;
              armed = 1;
            end
            if (arvalid && armed) begin
              if (arw_left > 0) begin
                arw_left--;
                arready = 0;
              end else arready = 1;
            end else arready = 0;
          end
        end
        if (phase == 1) begin
          if (r_hs) idx++;
          if (idx >= total) begin
            phase = 0; rvalid = 0; rlast = 0;
          end else if (!(rvalid && !r_hs)) begin
            rvalid = ($urandom_range(0, 99) >= gap);
            rdata  = base + 64'(idx);
            rresp  = (idx == err) ? 2'b10 : 2'b00;
            rlast  = (idx == total - 1);
          end
        end
      end
    end
  end

  // mode 0 normal, 1 early rlast on beat mparam, 2 rlast missing with mparam extra beats
  task automatic run_txn(input logic [31:0] byte_addr, input bit single, input int mode,
                         input int mparam, input int err, input int gap, input int arw,
                         input logic [63:0] base, input bit wait_done, input bit hold_req,
                         input bit chk_b2b);
    int    n, total, nexp, acks0;
    bit    got;
    beat_t b;
    ar_t   a;
    scfg_t c;
    n = single ? 1 : LB;
    a.addr = single ? {byte_addr[31:3], 3'b000} : (byte_addr & ~32'(LB * 8 - 1));
    a.len  = 8'(n - 1);
    case (mode)
      1:       begin total = mparam + 1; nexp = mparam + 1; end
      2:       begin total = n + mparam; nexp = n; end
      default: begin total = n;          nexp = n; end
    endcase
    for (int k = 0; k < nexp; k++) begin
      b.data  = base + 64'(k);
      b.last  = (k == nexp - 1);
      b.fault = (k == err) || (mode != 0 && k == nexp - 1);
      expq.push_back(b);
    end
    arq.push_back(a);
    c.total = total; c.err = err; c.gap = gap; c.arw = arw; c.base = base;
    cfgq.push_back(c);
    acks0 = ack_cnt;
    @(posedge clk);
    #1;
    icu_biu_req = 1'b1; icu_biu_addr = byte_addr[31:3]; icu_biu_single = single;
    got = 0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (biu_icu_ack) begin
        got = 1;
        txn_ack_cyc = cyc;
      end
    end
    chk("ack_seen", got, 1);
    if (chk_b2b) chk("b2b_ack_gap", txn_ack_cyc - last_dv_cyc, 1);
    if (hold_req) begin
      got = 0;
      for (int i = 0; i < 800 && !got; i++) begin
        @(negedge clk);
        if (biu_icu_data_valid && biu_icu_data_last) got = 1;
      end
      #1 icu_biu_req = 1'b0;
      chk("hold_last_seen", got, 1);
    end else begin
      @(posedge clk);
      #1 icu_biu_req = 1'b0;
    end
    if (wait_done) begin
      got = 0;
      for (int i = 0; i < 1000 && !got; i++) begin
        @(negedge clk);
        if (expq.size() == 0 && cfgq.size() == 0 && !rready && !arvalid) got = 1;
      end
      chk("txn_complete", got, 1);
      if (!got) begin
        expq.delete(); arq.delete(); cfgq.delete();
      end
      repeat (2) @(negedge clk);
      chk("one_ack", 64'(ack_cnt - acks0), 1);
    end
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_ack"}, biu_icu_ack, 0);
    chk({tag, "_dv"}, biu_icu_data_valid, 0);
    chk({tag, "_last"}, biu_icu_data_last, 0);
    chk({tag, "_fault"}, biu_icu_fault, 0);
    chk({tag, "_data"}, biu_icu_data, 0);
    chk({tag, "_arvalid"}, arvalid, 0);
    chk({tag, "_araddr"}, araddr, 0);
    chk({tag, "_arlen"}, arlen, 0);
    chk({tag, "_arsize"}, arsize, 0);
    chk({tag, "_arburst"}, arburst, 0);
    chk({tag, "_rready"}, rready, 0);
  endtask

  initial begin
    int          rx0, s, mode, mp, n, err;
    logic [31:0] ad;
    reset = 1'b0; icu_biu_req = 1'b0; icu_biu_addr = '0; icu_biu_single = 1'b0;
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 chk_outputs_zero("rst");
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(posedge clk);

    // best-case line fill with cycle-exact return timing
    dv_cycq.delete();
    run_txn(32'h0000_1048, 0, 0, 0, -1, 0, 0, 64'hA0, 1, 0, 0);
    chk("fill_beats", dv_cycq.size(), 4);
    for (int k = 0; k < 4 && k < dv_cycq.size(); k++)
      chk("fill_timing", dv_cycq[k] - txn_ack_cyc, 3 + k);

    // single-beat fetch
    run_txn(32'h8000_0010, 1, 0, 0, -1, 0, 0, 64'h1234_5678_9ABC_DEF0, 1, 0, 0);

    // AR stall with request held high, plus random rvalid gaps
    rx0 = beats_rx;
    run_txn(32'h0000_2210, 0, 0, 0, -1, 50, 5, 64'hBEEF_0000, 1, 1, 0);
    chk("gap_beat_count", beats_rx - rx0, 4);

    // slave error on beat 2
    run_txn(32'h0000_3000, 0, 0, 0, 2, 0, 0, 64'hC0, 1, 0, 0);
    // early rlast on beat 1
    run_txn(32'h0000_4020, 0, 1, 1, -1, 0, 0, 64'hD0, 1, 0, 0);
    // rlast missing on beat 3, two surplus beats drained
    rx0 = beats_rx;
    run_txn(32'h0000_5000, 0, 2, 2, -1, 0, 0, 64'hE0, 1, 0, 0);
    chk("drain_beat_count", beats_rx - rx0, 4);
    run_txn(32'h0000_5100, 1, 0, 0, -1, 0, 0, 64'hE8, 1, 0, 0);

    // request pending during the final beat is acked one cycle later
    run_txn(32'h0000_6000, 0, 0, 0, -1, 0, 0, 64'hF0, 0, 0, 0);
    run_txn(32'h0000_6100, 1, 0, 0, -1, 0, 0, 64'hF8, 1, 0, 1);

    // asynchronous reset while beat 2 is being returned
    rx0 = beats_rx;
    run_txn(32'h0000_7000, 0, 0, 0, -1, 0, 0, 64'h55AA_0000_0000_0010, 0, 0, 0);
    for (int i = 0; i < 50 && (beats_rx - rx0) < 2; i++) @(posedge clk);
    #2 reset = 1'b1;
    #1 chk_outputs_zero("midrst");
    expq.delete(); arq.delete(); cfgq.delete();
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    run_txn(32'h0000_7040, 0, 0, 0, -1, 0, 0, 64'h77, 1, 0, 0);

    // randomized traffic
    for (int t = 0; t < 30; t++) begin
      s    = ($urandom_range(0, 3) == 0);
      n    = s ? 1 : LB;
      mode = $urandom_range(0, 5);
      mp   = 0;
      if (mode == 4 && n >= 2) begin
        mode = 1;
        mp = $urandom_range(0, n - 2);
      end else if (mode == 5) begin
        mode = 2;
        mp = $urandom_range(1, 3);
      end else mode = 0;
      err = ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(0, LB - 1));
      ad  = $urandom & 32'hFFFF_FFF8;
      run_txn(ad, s[0], mode, mp, err, $urandom_range(0, 60), $urandom_range(0, 4),
              {$urandom, $urandom}, 1, 0, 0);
    end

    chk("scoreboard_drained", expq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
